viterbi_dec_k3: RTL
===================

VITERBI_DEC_K3 -- requirements
Module: viterbi_dec_k3

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16: symbols per frame, last 2 are encoder tail (info bits 0); legal range 3..256.
REQ-002 SHALL have parameter PM_W, default 5: path-metric width in bits, minimum 4.
REQ-003 i_clk  input  1  clock, all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  received symbol present on i_data this cycle.
REQ-006 i_data  input  2  received hard-decision symbol {b1,b0}; b0 = G 111 output, b1 = G 101 output.
REQ-007 o_ready  output  1  decoder accepts a symbol this cycle.
REQ-008 o_valid  output  1  decoded bit present on o_bit.
REQ-009 o_bit  output  1  decoded information bit, forward (transmit) order.
REQ-010 o_last  output  1  marks last decoded bit of frame, qualified by o_valid.
REQ-011 i_ready  input  1  downstream accepts o_bit this cycle.

Function
REQ-012 Trellis SHALL be K=3, 4 states s={d1,d2} (d1 = previous input bit); input u moves s to {u,d1}; expected b0=u^d1^d2, b1=u^d2.
REQ-013 Symbol accepted when i_valid && o_ready; i_valid with o_ready low SHALL be ignored, with no state change.
REQ-014 FSM states: IDLE, ACS, TRACE, OUT.
REQ-015 IDLE: o_ready=1; PM[0]=0, PM[1..3]=all-ones; first accepted symbol is processed and moves the FSM to ACS.
REQ-016 ACS: o_ready=1; gaps in i_valid allowed; after the FRAME_LEN-th accepted symbol, the FSM moves to TRACE next cycle.
REQ-017 Branch metric: Hamming distance (0..2) between i_data and expected {b1,b0}.
REQ-018 ACS per next state {u,a}: candidates from predecessors {a,0} and {a,1}; select smaller PM+BM; a tie SHALL select {a,0}.
REQ-019 Additions SHALL saturate at all-ones.
REQ-020 After each step, the minimum of the 4 new metrics SHALL be subtracted from all of them, so at least one metric is 0.
REQ-021 Survivor memory SHALL store, per step, one bit per state (the selected predecessor's d2): FRAME_LEN x 4 bits.
REQ-022 TRACE: start at state 0 at step FRAME_LEN-1; one step per cycle; decoded bit = state MSB; predecessor = {state[0], survivor bit}; exactly FRAME_LEN cycles.
REQ-023 TRACE SHALL write decoded bits into an output buffer indexed by step; tail bits (steps FRAME_LEN-2, FRAME_LEN-1) are discarded.
REQ-024 OUT: emit buffer bits 0..FRAME_LEN-3 in order.
REQ-025 In OUT, o_valid=1 and o_bit=buffer[idx]; idx advances only on o_valid && i_ready, and o_bit SHALL remain stable while i_ready=0.
REQ-026 o_last=1 with the bit at idx FRAME_LEN-3; the transfer of that bit SHALL move the FSM to IDLE, with o_ready=1 the next cycle.
REQ-027 o_ready=0 in TRACE and OUT; upstream SHALL gate its start during those states.
REQ-028 Latency: if the last symbol is accepted at edge N, o_valid SHALL rise after edge N+FRAME_LEN+1.
REQ-029 A single-bit symbol error separated from other errors by at least 5 symbols SHALL be corrected.

Reset
REQ-030 On i_rst_n low, the FSM SHALL go to IDLE immediately and clear the step counter and output index.
REQ-031 On reset, PM[0]=0, PM[1..3]=all-ones, o_valid=0, o_last=0, o_bit=0, o_ready=1 after release.
REQ-032 Reset mid-frame (any state) SHALL discard the partial frame and all buffered bits; survivor memory need not be cleared.

Verification
REQ-033 FRAME_LEN=6; symbols 11,01,00,10,10,11 back-to-back -> o_bit 1,0,1,1, o_last on 4th, o_valid first after edge N+7.
REQ-034 Same frame with 3rd symbol corrupted to 01 -> output still 1,0,1,1.
REQ-035 FRAME_LEN=6; six 00 symbols with idle gaps of 1-3 cycles between them -> output 0,0,0,0, no o_valid before the 6th symbol.
REQ-036 Clean frame with i_ready held 0 for 5 cycles at the 2nd bit -> o_bit=0 held stable, then 1,1 follow, no bit lost or duplicated.
REQ-037 Assert i_rst_n low after the 3rd symbol, then send a clean frame -> only the second frame's 1,0,1,1 appears.
REQ-038 i_valid held high during TRACE/OUT with random data -> ignored; o_ready=0 throughout; next frame decodes correctly.

Source files
------------

// File: rtl/viterbi_dec_k3.sv
// Hard-decision Viterbi decoder for the K=3 (7,5) code: one ACS step per accepted
// symbol, full-frame traceback into an output buffer, then in-order bit emission.
module viterbi_dec_k3 #(
  parameter int FRAME_LEN = 16,
  parameter int PM_W      = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [1:0] i_data,
  output logic       o_ready,
  output logic       o_valid,
  output logic       o_bit,
  output logic       o_last,
  input  logic       i_ready,
  output logic [1:0] o_dbg_state
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int SA_W  = $clog2(FRAME_LEN);
  localparam int OUT_N = FRAME_LEN - 2;
  localparam int IDX_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_OUTN = CNT_W'(OUT_N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_N - 1);

  localparam logic [PM_W-1:0]        PM_MAX  = '1;
  localparam logic [3:0][PM_W-1:0]   PM_INIT = {PM_MAX, PM_MAX, PM_MAX, {PM_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACS   = 2'd1,
    S_TRACE = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [1:0]              tstate_q, tstate_d;
  logic [3:0][PM_W-1:0]    pm_q, pm_d;
  logic [OUT_N-1:0]        obuf_q, obuf_d;
  logic [3:0]              surv_q [FRAME_LEN];
  logic                    surv_we;

  logic [3:0][PM_W-1:0]    pm_cur, pm_acs, pm_norm;
  logic [3:0]              surv_new;
  logic [PM_W-1:0]         c0, c1, m_lo, m_hi, m_min;
  logic [1:0]              ns_b;
  logic                    surv_bit;

  // Expected symbol for input u leaving state {d1,d2} is {u^d2, u^d1^d2}.
  function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic u,
                                               input logic d1, input logic d2);
    logic [1:0] diff;
    diff = rx ^ {u ^ d2, u ^ d1 ^ d2};
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  // The first symbol of a frame always starts from the known encoder state 0.
  assign pm_cur      = (state_q == S_IDLE) ? PM_INIT : pm_q;
  assign o_dbg_state = state_q;

  always_comb begin
    pm_acs   = '0;
    surv_new = '0;
    c0       = '0;
    c1       = '0;
    ns_b     = '0;
    for (int ns = 0; ns < 4; ns++) begin
      ns_b = 2'(ns);
      c0 = sat_add(pm_cur[{ns_b[0], 1'b0}], branch_metric(i_data, ns_b[1], ns_b[0], 1'b0));
      c1 = sat_add(pm_cur[{ns_b[0], 1'b1}], branch_metric(i_data, ns_b[1], ns_b[0], 1'b1));
      if (c1 < c0) begin
        pm_acs[ns_b]   = c1;
        surv_new[ns_b] = 1'b1;
      end else begin
        pm_acs[ns_b]   = c0;
        surv_new[ns_b] = 1'b0;
      end
    end
    m_lo  = (pm_acs[1] < pm_acs[0]) ? pm_acs[1] : pm_acs[0];
    m_hi  = (pm_acs[3] < pm_acs[2]) ? pm_acs[3] : pm_acs[2];
    m_min = (m_hi < m_lo) ? m_hi : m_lo;
    for (int s = 0; s < 4; s++) begin
      pm_norm[s] = pm_acs[s] - m_min;
    end
  end

  assign surv_bit = surv_q[cnt_q[SA_W-1:0]][tstate_q];

  // Handshake: a symbol is consumed on a rising edge where i_valid && o_ready;
  // a decoded bit is consumed on a rising edge where o_valid && i_ready, and
  // o_bit/o_last hold their value until that happens.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tstate_d = tstate_q;
    pm_d     = pm_q;
    obuf_d   = obuf_q;
    surv_we  = 1'b0;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    o_bit    = 1'b0;
    o_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        pm_d    = PM_INIT;
        if (i_valid) begin
          pm_d    = pm_norm;
          surv_we = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = S_ACS;
        end
      end
      S_ACS: begin
        // The cycle after the final symbol is a turnaround: no further intake.
        if (cnt_q == CNT_DONE) begin
          state_d  = S_TRACE;
          cnt_d    = CNT_TOP;
          tstate_d = 2'b00;
        end else begin
          o_ready = 1'b1;
          if (i_valid) begin
            pm_d    = pm_norm;
            surv_we = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      S_TRACE: begin
        if (cnt_q < CNT_OUTN) begin
          obuf_d[cnt_q[IDX_W-1:0]] = tstate_q[1];
        end
        tstate_d = {tstate_q[0], surv_bit};
        if (cnt_q == '0) begin
          state_d = S_OUT;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_OUT: begin
        o_valid = 1'b1;
        o_bit   = obuf_q[idx_q];
        o_last  = (idx_q == IDX_LAST);
        if (i_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      tstate_q <= '0;
      pm_q     <= PM_INIT;
      obuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tstate_q <= tstate_d;
      pm_q     <= pm_d;
      obuf_q   <= obuf_d;
    end
  end

  // Survivor memory is only ever read at steps written in the current frame.
  always_ff @(posedge i_clk) begin
    if (surv_we) begin
      surv_q[cnt_q[SA_W-1:0]] <= surv_new;
    end
  end

endmodule
